uart_rx: RTL

- 8-bit asynchronous serial receiver; the receive-side counterpart of the team's uart_tx.
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity, 1 stop bit (1).
- Default timing is 115200 bps from a 100 MHz clock. Each bit is sampled once at mid-bit.
- Delivers each received byte to the host logic as a one-cycle valid pulse and flags framing errors.

---
 rtl/uart_rx.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, 1 start / 8 data LSB first / 1 stop, mid-bit sampling.
// Optional parity bit enabled by defining UART_RX_PARITY_EN (sense set by PARITY_ODD).
module uart_rx #(
  parameter logic [14:0] BAUD_DIV   = 15'd867,
  parameter logic [14:0] HALF_DIV   = 15'd433,
  parameter logic        PARITY_ODD = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic       uart_rx_i,
  output logic [7:0] uart_rx_data_o,
  output logic       uart_rx_valid_o,
  output logic       uart_rx_busy,
  output logic       uart_rx_frame_err_o,
  output logic       uart_rx_parity_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  state_e      state_r;
  state_e      state_next_s;
  logic [14:0] cnt_r;
  logic [14:0] cnt_next_s;
  logic [2:0]  bit_idx_r;
  logic [2:0]  bit_idx_next_s;
  logic [7:0]  shift_r;
  logic [7:0]  shift_next_s;
  logic        par_bad_r;
  logic        par_bad_next_s;
  logic [7:0]  data_next_s;
  logic        valid_next_s;
  logic        ferr_next_s;
  logic        perr_next_s;
  logic        busy_next_s;

  logic        sync1_r;
  logic        sync2_r;
  logic        prev_r;
  logic        line_s;
  logic        fall_s;

`ifdef UART_RX_PARITY_EN
  logic        perr_r;

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  assign line_s = sync2_r;
  assign fall_s = prev_r & ~sync2_r;

  // Two-flop synchronizer plus one history flop for start-edge detection
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= uart_rx_i;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Next-state, counter, shift register and output pulse decode
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r + 15'd1;
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_r;
    par_bad_next_s = par_bad_r;
    data_next_s    = uart_rx_data_o;
    valid_next_s   = 1'b0;
    ferr_next_s    = 1'b0;
    perr_next_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cnt_next_s     = 15'd0;
        bit_idx_next_s = 3'd0;
        par_bad_next_s = 1'b0;
        if (fall_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_r == HALF_DIV) begin
          cnt_next_s     = 15'd0;
          bit_idx_next_s = 3'd0;
          // A line back high at mid-start is treated as a glitch
          if (line_s == 1'b0) begin
            state_next_s = ST_DATA;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_START;
        end
      end

      ST_DATA: begin
        if (cnt_r == BAUD_DIV) begin
          cnt_next_s              = 15'd0;
          shift_next_s[bit_idx_r] = line_s;
          bit_idx_next_s          = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_r == BAUD_DIV) begin
          cnt_next_s     = 15'd0;
          par_bad_next_s = line_s ^ parity8(shift_r) ^ PARITY_ODD;
          state_next_s   = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
`endif

      ST_STOP: begin
        if (cnt_r == BAUD_DIV) begin
          cnt_next_s   = 15'd0;
          state_next_s = ST_IDLE;
          // Framing error wins over a pending parity error
          if (line_s == 1'b1) begin
            if (par_bad_r) begin
              perr_next_s = 1'b1;
            end else begin
              valid_next_s = 1'b1;
              data_next_s  = shift_r;
            end
          end else begin
            ferr_next_s = 1'b1;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end

      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 15'd0;
      end
    endcase

    busy_next_s = (state_next_s != ST_IDLE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_r             <= ST_IDLE;
      cnt_r               <= 15'd0;
      bit_idx_r           <= 3'd0;
      shift_r             <= 8'h00;
      par_bad_r           <= 1'b0;
      uart_rx_data_o      <= 8'h00;
      uart_rx_valid_o     <= 1'b0;
      uart_rx_frame_err_o <= 1'b0;
      uart_rx_busy        <= 1'b0;
    end else begin
      state_r             <= state_next_s;
      cnt_r               <= cnt_next_s;
      bit_idx_r           <= bit_idx_next_s;
      shift_r             <= shift_next_s;
      par_bad_r           <= par_bad_next_s;
      uart_rx_data_o      <= data_next_s;
      uart_rx_valid_o     <= valid_next_s;
      uart_rx_frame_err_o <= ferr_next_s;
      uart_rx_busy        <= busy_next_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse register
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      perr_r <= 1'b0;
    end else begin
      perr_r <= perr_next_s;
    end
  end

  assign uart_rx_parity_err_o = perr_r;
`else
  logic unused_parity_s;

  assign unused_parity_s      = PARITY_ODD ^ perr_next_s;
  assign uart_rx_parity_err_o = 1'b0;
`endif

endmodule
